// File: rtl/jt900h_mul.sv
// rtl/jt900h_mul.sv - shift-add 8x8/16x16 signed/unsigned multiplier, one bit per cen cycle
module jt900h_mul (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        start,
  input  logic        sign,
  output logic [31:0] prod,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      st;
  logic        start_l, len_l, rsi;
  logic [3:0]  cnt;
  logic [31:0] acc, mcand;
  logic [15:0] mplier;

  logic        trigger, s0, s1, last;
  logic [15:0] m0, m1;
  logic [31:0] sum, res;

  assign trigger = start & ~start_l;

  // Magnitudes are kept unsigned, so 0x80 and 0x8000 map to 128 and 32768 without overflow
  always_comb begin
    s0 = len ? op0[15] : op0[7];
    s1 = len ? op1[15] : op1[7];
    if (len) begin
      m0 = (sign & s0) ? (~op0 + 16'd1) : op0;
      m1 = (sign & s1) ? (~op1 + 16'd1) : op1;
    end else begin
      m0 = {8'd0, (sign & s0) ? (~op0[7:0] + 8'd1) : op0[7:0]};
      m1 = {8'd0, (sign & s1) ? (~op1[7:0] + 8'd1) : op1[7:0]};
    end
    sum  = acc + (mplier[0] ? mcand : 32'd0);
    last = len_l ? (cnt == 4'd15) : (cnt == 4'd7);
    if (!rsi)
      res = sum;
    else if (len_l)
      res = ~sum + 32'd1;
    else
      res = {16'd0, ~sum[15:0] + 16'd1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      start_l <= 1'b0;
      cnt     <= 4'd0;
      rsi     <= 1'b0;
      len_l   <= 1'b0;
      prod    <= 32'd0;
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 16'd0;
    end else if (cen) begin
      start_l <= start;
      done    <= 1'b0;
      if (st == IDLE) begin
        if (trigger) begin
          st     <= RUN;
          busy   <= 1'b1;
          len_l  <= len;
          rsi    <= sign & (s0 ^ s1);
          acc    <= 32'd0;
          mcand  <= {16'd0, m0};
          mplier <= m1;
          cnt    <= 4'd0;
        end
      end else begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 4'd1;
        if (last) begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          prod <= res;
          cnt  <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt900h_mul.sv
// tb/tb_jt900h_mul.sv - scoreboard bench for jt900h_mul with directed vectors
module tb_jt900h_mul;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        cen = 1'b1;
  logic [15:0] op0 = 16'd0;
  logic [15:0] op1 = 16'd0;
  logic        len = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] prod;
  logic        busy, done;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic        done_q = 1'b0;
  logic        cen_tog = 1'b0;
  logic [31:0] last_prod = 32'd0;

  jt900h_mul dut (
    .rst(rst), .clk(clk), .cen(cen), .op0(op0), .op1(op1), .len(len),
    .start(start), .sign(sign), .prod(prod), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cen_tog) cen = ~cen;
    else         cen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done pops one expected product
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got prod %h expected no completion", prod);
      end else begin
        check("prod", prod, exp_q.pop_front());
      end
    end
    done_q = done;
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic l,
                        input logic s, input logic [31:0] exp, input int exp_busy,
                        input int hold);
    int bc;
    bit seen;
    bc = 0;
    seen = 0;
    @(negedge clk);
    op0 = a; op1 = b; len = l; sign = s; start = 1'b1;
    exp_q.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == hold - 1) start = 1'b0;
      if (busy) begin
        if (bc == 0) begin
          check("prod_hold", prod, last_prod);
          op0 = 16'h5A5A; op1 = 16'hA5A5; len = ~l; sign = ~s;
        end
        bc++;
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_len", bc, exp_busy);
    last_prod = exp;
    if (!cen_tog) begin
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int dn;
    int bc;
    repeat (3) @(negedge clk);
    check("rst_prod", prod, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFE0001, 16, 1);
    run_op(16'h0080, 16'h007F, 1'b0, 1'b1, 32'h0000C080, 8, 1);
    run_op(16'h0080, 16'h0080, 1'b0, 1'b1, 32'h00004000, 8, 1);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 16, 1);
    run_op(16'hFFFF, 16'h0002, 1'b1, 1'b1, 32'hFFFFFFFE, 16, 1);
    run_op(16'hFFFB, 16'h0000, 1'b1, 1'b1, 32'h00000000, 16, 1);
    run_op(16'hABFF, 16'h12FF, 1'b0, 1'b0, 32'h0000FE01, 8, 1);
    run_op(16'h00FE, 16'h0003, 1'b0, 1'b1, 32'h0000FFFA, 8, 1);
    run_op(16'h1234, 16'hFFFF, 1'b1, 1'b1, 32'hFFFFEDCC, 16, 1);

    cen_tog = 1'b1;
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFE0001, 32, 2);
    cen_tog = 1'b0;
    repeat (3) @(negedge clk);

    // start held high for 40 cycles must give one operation
    dn = 0;
    op0 = 16'h0007; op1 = 16'h0009; len = 1'b1; sign = 1'b0; start = 1'b1;
    exp_q.push_back(32'h0000003F);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 40) start = 1'b0;
      if (done) dn++;
    end
    check("held_start_ops", dn, 1);
    last_prod = 32'h0000003F;

    // second rising edge while busy is ignored
    dn = 0;
    op0 = 16'h0010; op1 = 16'h0010; start = 1'b1;
    exp_q.push_back(32'h00000100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 4) begin start = 1'b1; op0 = 16'hFFFF; op1 = 16'hFFFF; end
      if (i == 5) start = 1'b0;
      if (i == 10) check("busy_prod_unchanged", prod, 32'h0000003F);
      if (done) dn++;
    end
    check("retrigger_ops", dn, 1);
    last_prod = 32'h00000100;

    // reset at iteration 5 aborts the op
    op0 = 16'h1234; op1 = 16'h5678; len = 1'b1; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_prod", prod, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    op0 = 16'h0003; op1 = 16'h0004; len = 1'b1; sign = 1'b0; start = 1'b1;
    exp_q.push_back(32'h0000000C);
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dn++;
      if (dn != 0 && i > 30) break;
    end
    start = 1'b0;
    check("post_rst_busy", bc, 16);
    check("post_rst_done", dn, 1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
